qmult_pipe: RTL and testbench
=============================

// Module: qmult_pipe
// PURPOSE
//  Pipelined signed fixed-point (Q-format) multiplier with valid/ready handshake, selectable rounding,
//  overflow detection and a sticky overflow flag. Successor to the combinational Q multiplier used in
//  the SOML decoder datapath; sits between operand producers and accumulators in the decoder/pipeline core.
//  Full two's-complement product (no sign-magnitude path), so -2^(N-1) operands are exact.
// PARAMETERS
//  N       16  operand/result width (two's complement), N>=4
//  Q       8   fractional bits, 1<=Q<=N-2
//  STAGES  2   pipeline depth = accept-to-output latency in cycles, STAGES>=1
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  i_valid       in   1   operand pair valid
//  o_ready       out  1   block can accept operands this cycle
//  i_multiplicand in  N   signed Q-format operand A
//  i_multiplier  in   N   signed Q-format operand B
//  i_round       in   1   0 = truncate (floor), 1 = round-half-up; sampled with operands
//  o_valid       out  1   result valid
//  i_ready       in   1   downstream accepts result this cycle
//  o_result      out  N   signed Q-format product
//  o_ovr         out  1   overflow flag for the current o_result
//  o_ovr_sticky  out  1   set on any transferred result with o_ovr=1
//  i_clr_ovr     in   1   synchronous clear of o_ovr_sticky
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits 0, o_valid=0, o_result=0, o_ovr=0,
//    o_ovr_sticky=0. Operations in flight are discarded; no output appears for them after reset.
//  - Handshake: adv = !o_valid || i_ready; o_ready = adv. Input transfer = i_valid && o_ready.
//    Output transfer = o_valid && i_ready. When adv=0 every stage (data, valid, round) holds.
//  - All stages shift together on adv; bubbles propagate as valid=0 and are not compressed.
//  - Latency: a transfer in cycle t yields o_valid in cycle t+STAGES if adv stays 1.
//    Throughput 1 result/cycle with i_ready held high.
//  - o_result, o_ovr stable while o_valid=1 && i_ready=0.
//  - Arithmetic: P = signed(A)*signed(B), 2N bits. Rounded R = (P + (i_round ? 2^(Q-1) : 0)) >>> Q
//    (arithmetic shift, 2N+1-bit intermediate, no internal wrap).
//    o_ovr = 1 iff R outside [-2^(N-1), 2^(N-1)-1].
//  - Product computed in stage 1; round/shift/overflow/saturate in the final stage
//    (same stage when STAGES=1). Extra stages are pure register stages.
//  - Sticky: on output transfer with o_ovr=1, o_ovr_sticky<=1. i_clr_ovr=1 clears it.
//    Simultaneous set and clear: set wins (flag stays 1).
//  - o_valid=0: o_result/o_ovr hold last value; they are not checked by the bench.
// CONFIGURATION
//  QMULT_SAT_EN defined: on overflow o_result clamps to 2^(N-1)-1 (R>0) or -2^(N-1) (R<0);
//    o_ovr still asserted.
//  QMULT_SAT_EN undefined: o_result = R[N-1:0] (wrap); o_ovr asserted.
// TESTING (N=16, Q=8, STAGES=2)
//  1) 0x0180*0x0200, round=0 -> o_result=0x0300, o_ovr=0, o_valid exactly 2 cycles after accept.
//  2) 0xFE80*0x0200 -> 0xFD00, ovr=0.
//     0x8000*0x0100 -> 0x8000, ovr=0 (exact -128*1).
//  3) 0x0001*0x0080: round=0 -> 0x0000; round=1 -> 0x0001.
//     0xFFFF*0x0080 round=0 -> 0xFFFF.
//  4) 0x7F00*0x0200 -> ovr=1; SAT_EN: 0x7FFF, else 0xFE00; o_ovr_sticky=1 next cycle.
//     0x8000*0x8000 -> SAT_EN 0x7FFF, ovr=1.
//  5) Stream 6 ops, i_ready low 5 cycles mid-stream -> o_ready low, outputs frozen,
//     all 6 results in order, none lost or duplicated.
//  6) rst_n low 1 cycle with 2 ops in flight -> all outputs 0 immediately, no stale result afterwards;
//     i_clr_ovr with overflow transfer in the same cycle -> sticky stays 1.

Source files
------------

// File: rtl/qmult_pipe.sv
// rtl/qmult_pipe.sv - pipelined signed Q-format multiplier with valid/ready, rounding and overflow flags
// Optional feature: QMULT_SAT_EN (saturate on overflow instead of wrapping).
module qmult_pipe #(
  parameter int N      = 16,
  parameter int Q      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_round,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  output logic         o_ovr_sticky,
  input  logic         i_clr_ovr
);

  localparam int W = 2 * N;

  logic                adv;
  logic signed [W-1:0] prod;
  logic signed [W-1:0] fin_p;
  logic                fin_rnd;
  logic                fin_vld;

  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;
  assign prod    = W'($signed(i_multiplicand)) * W'($signed(i_multiplier));

  // Product register plus STAGES-2 plain delay stages; the output register is the last stage.
  generate
    if (STAGES == 1) begin : g_direct
      assign fin_p   = prod;
      assign fin_rnd = i_round;
      assign fin_vld = i_valid;
    end else begin : g_pipe
      localparam int D = STAGES - 1;
      logic signed [W-1:0] p_q [D];
      logic [D-1:0]        rnd_q;
      logic [D-1:0]        vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) p_q[k] <= '0;
          rnd_q <= '0;
          vld_q <= '0;
        end else if (adv) begin
          p_q[0]   <= prod;
          rnd_q[0] <= i_round;
          vld_q[0] <= i_valid;
          for (int k = 1; k < D; k++) begin
            p_q[k]   <= p_q[k-1];
            rnd_q[k] <= rnd_q[k-1];
            vld_q[k] <= vld_q[k-1];
          end
        end
      end

      assign fin_p   = p_q[D-1];
      assign fin_rnd = rnd_q[D-1];
      assign fin_vld = vld_q[D-1];
    end
  endgenerate

  logic [W:0]        ext;
  logic signed [W:0] r;
  logic              ovr_c;
  logic [N-1:0]      res_c;

  // One extra bit of headroom so the rounding add can never wrap.
  always_comb begin
    ext   = {fin_p[W-1], fin_p} + ((W+1)'(fin_rnd) << (Q - 1));
    r     = $signed(ext) >>> Q;
    ovr_c = !((&r[W:N-1]) || !(|r[W:N-1]));
    res_c = r[N-1:0];
`ifdef QMULT_SAT_EN
    if (ovr_c) res_c = r[W] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_ovr    <= 1'b0;
    end else if (adv) begin
      o_valid <= fin_vld;
      if (fin_vld) begin
        o_result <= res_c;
        o_ovr    <= ovr_c;
      end
    end
  end

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         o_ovr_sticky <= 1'b0;
    else if (o_valid && i_ready && o_ovr) o_ovr_sticky <= 1'b1;
    else if (i_clr_ovr)                 o_ovr_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_qmult_pipe.sv
// tb/tb_qmult_pipe.sv - directed table-driven bench for qmult_pipe (N=16, Q=8, STAGES=2)
module tb_qmult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_multiplicand;
  logic [15:0] i_multiplier;
  logic        i_round;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_result;
  logic        o_ovr;
  logic        o_ovr_sticky;
  logic        i_clr_ovr;

  qmult_pipe #(.N(16), .Q(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier), .i_round(i_round),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_ovr(o_ovr),
    .o_ovr_sticky(o_ovr_sticky), .i_clr_ovr(i_clr_ovr)
  );

  always #5 clk = ~clk;

`ifdef QMULT_SAT_EN
  localparam logic [15:0] OV_POS_A = 16'h7FFF;
  localparam logic [15:0] OV_POS_B = 16'h7FFF;
  localparam logic [15:0] OV_NEG   = 16'h8000;
`else
  localparam logic [15:0] OV_POS_A = 16'hFE00;
  localparam logic [15:0] OV_POS_B = 16'h0000;
  localparam logic [15:0] OV_NEG   = 16'h0000;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        rnd;
    logic [15:0] res;
    logic        ovr;
  } vec_t;

  vec_t        vt [13];
  int          n_vec = 0;
  int          n_err = 0;
  logic        sticky_model = 1'b0;
  logic [15:0] s_exp [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    i_valid = 1'b1; i_multiplicand = vt[i].a; i_multiplier = vt[i].b; i_round = vt[i].rnd;
    @(negedge clk);
    i_valid = 1'b0;
    check($sformatf("latency_v%0d", i), {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    check($sformatf("valid_v%0d", i), {31'd0, o_valid}, 32'd1);
    check($sformatf("result_v%0d", i), {16'd0, o_result}, {16'd0, vt[i].res});
    check($sformatf("ovr_v%0d", i), {31'd0, o_ovr}, {31'd0, vt[i].ovr});
    sticky_model = sticky_model | vt[i].ovr;
    @(negedge clk);
    check($sformatf("sticky_v%0d", i), {31'd0, o_ovr_sticky}, {31'd0, sticky_model});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{16'h0180, 16'h0200, 1'b0, 16'h0300, 1'b0};
    vt[1]  = '{16'hFE80, 16'h0200, 1'b0, 16'hFD00, 1'b0};
    vt[2]  = '{16'h8000, 16'h0100, 1'b0, 16'h8000, 1'b0};
    vt[3]  = '{16'h0001, 16'h0080, 1'b0, 16'h0000, 1'b0};
    vt[4]  = '{16'h0001, 16'h0080, 1'b1, 16'h0001, 1'b0};
    vt[5]  = '{16'hFFFF, 16'h0080, 1'b0, 16'hFFFF, 1'b0};
    vt[6]  = '{16'hFFFF, 16'h0080, 1'b1, 16'h0000, 1'b0};
    vt[7]  = '{16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0};
    vt[8]  = '{16'h00C0, 16'h0001, 1'b1, 16'h0001, 1'b0};
    vt[9]  = '{16'h0101, 16'h0101, 1'b1, 16'h0102, 1'b0};
    vt[10] = '{16'h7F00, 16'h0200, 1'b0, OV_POS_A, 1'b1};
    vt[11] = '{16'h8000, 16'h8000, 1'b0, OV_POS_B, 1'b1};
    vt[12] = '{16'h8000, 16'h0200, 1'b0, OV_NEG,   1'b1};
    s_exp[0] = 16'h0180; s_exp[1] = 16'h0300; s_exp[2] = 16'h0480;
    s_exp[3] = 16'h0600; s_exp[4] = 16'h0780; s_exp[5] = 16'h0900;

    rst_n = 1'b0; i_valid = 1'b0; i_multiplicand = '0; i_multiplier = '0;
    i_round = 1'b0; i_ready = 1'b1; i_clr_ovr = 1'b0;
    #12;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_result", {16'd0, o_result}, 32'd0);
    check("rst_ovr", {31'd0, o_ovr}, 32'd0);
    check("rst_sticky", {31'd0, o_ovr_sticky}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Streaming with a 5-cycle downstream stall
    begin
      int sent = 0;
      int recv = 0;
      logic stalled_prev = 1'b0;
      logic [15:0] held = '0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        i_ready = !(c >= 4 && c < 9);
        i_valid = (sent < 6);
        i_multiplicand = 16'((sent + 1) << 8);
        i_multiplier = 16'h0180;
        i_round = 1'b0;
        #1;
        if (c == 6) check("stall_ready", {31'd0, o_ready}, 32'd0);
        if (o_valid && !i_ready) begin
          if (stalled_prev) check($sformatf("frozen_c%0d", c), {16'd0, o_result}, {16'd0, held});
          held = o_result;
          stalled_prev = 1'b1;
        end else begin
          stalled_prev = 1'b0;
        end
        if (o_valid && i_ready) begin
          if (recv < 6) begin
            check($sformatf("stream_r%0d", recv), {16'd0, o_result}, {16'd0, s_exp[recv]});
          end else begin
            n_vec++; n_err++;
            $display("FAIL stream_extra: got result %h expected none", o_result);
          end
          recv++;
        end
        if (i_valid && o_ready) sent++;
      end
      i_valid = 1'b0;
      check("stream_count", recv, 32'd6);
    end

    // Reset with two operations in flight
    @(negedge clk); i_valid = 1'b1; i_multiplicand = 16'h7F00; i_multiplier = 16'h0200;
    @(negedge clk); i_multiplicand = 16'h0180;
    @(negedge clk); i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst2_valid", {31'd0, o_valid}, 32'd0);
    check("rst2_result", {16'd0, o_result}, 32'd0);
    check("rst2_sticky", {31'd0, o_ovr_sticky}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    begin
      logic stale = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (o_valid) stale = 1'b1;
      end
      check("no_stale", {31'd0, stale}, 32'd0);
    end

    // Clear coinciding with an overflow transfer: set wins
    @(negedge clk); i_valid = 1'b1; i_multiplicand = 16'h7F00; i_multiplier = 16'h0200;
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk);
    check("clr_set_valid", {31'd0, o_valid}, 32'd1);
    i_clr_ovr = 1'b1;
    @(negedge clk);
    check("clr_set_sticky", {31'd0, o_ovr_sticky}, 32'd1);
    @(negedge clk);
    check("clr_only_sticky", {31'd0, o_ovr_sticky}, 32'd0);
    i_clr_ovr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
